// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both transmitter and receiver.
// Bit period helper derives the clock-enable divider from the baud setup.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   function automatic int calc_div(input int baud_rate,
                                   input int clock_freq);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period clock enable: one-cycle tick every DIV cycles.
// restart_i zeroes the count so the next tick lands DIV cycles later.
module uart_baud_tick #(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);

   if (DIV < 2 || DIV > 65535) begin : g_div_chk
      $error("uart_baud_tick: DIV must be in 2..65535");
   end

   localparam logic [15:0] LAST = 16'(DIV - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 16'd1;
      if (restart_i || cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   assign tick_o = (cnt_q == LAST) && !restart_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, valid/ready byte input.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1).
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 38400000,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       soft_reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int DIV = calc_div(BAUD_RATE, CLOCK_FREQ);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   if (STOP_BITS != 1) begin : g_stop_chk
      $error("uart_tx: only one stop bit supported");
   end

   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic        tx_q, tx_d;
   logic        done_q, done_d;
   logic        accept;
   logic        restart;
   logic        tick;
`ifdef UART_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   uart_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .restart_i(restart),
      .tick_o   (tick)
   );

   assign in_ready = (state_q == IDLE) && !soft_reset;
   assign restart  = accept || soft_reset;

   // tx_d always reflects the line level of state_d so tx stays registered
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = START;
               shift_d = in_data;
               idx_d   = '0;
               tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_d   = (^in_data) ^ 1'(PARITY_ODD);
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // Abort wins over any handshake or frame step in the same cycle
      if (soft_reset) begin
         state_d = IDLE;
         shift_d = '0;
         idx_d   = '0;
         tx_d    = 1'b1;
         done_d  = 1'b0;
         accept  = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx   = tx_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=16 (CLOCK_FREQ=160, BAUD_RATE=10).
// Frames are checked bit by bit against hand-built line patterns.
module tb_uart_tx;

   localparam int CF   = 160;
   localparam int BR   = 10;
   localparam int DIV  = 16;
   localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NB   = 11;
`else
   localparam int NB   = 10;
`endif
   localparam int FLEN = NB * DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       soft_reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .BAUD_RATE (BR),
      .CLOCK_FREQ(CF),
      .PARITY_ODD(PODD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .soft_reset(soft_reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // bit 0 = start bit, then data LSB first, optional parity, stop
   function automatic logic [10:0] full(input logic [7:0] d,
                                        input logic [9:0] f);
`ifdef UART_TX_PARITY_EN
      logic p;
      p = (^d) ^ 1'(PODD);
      return {1'b1, p, f[8:0]};
`else
      return {1'b0, f};
`endif
   endfunction

   task automatic send(input logic [7:0] d, input bit hold);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("send ready timeout", n, 0);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // call #1 after the accept edge; sample s is at negedge after edge s
   task automatic check_frame(input string nm, input logic [10:0] f,
                              input int upto, input int pulse_at);
      int ok[11];
      int nd;
      int nb;
      nd = 0;
      nb = 0;
      for (int b = 0; b < 11; b++) ok[b] = 0;
      for (int s = 0; s < upto; s++) begin
         @(negedge clk);
         if (pulse_at >= 0 && s == pulse_at) begin
            in_data  = 8'h3C;
            in_valid = 1'b1;
         end else if (pulse_at >= 0 && s == pulse_at + 1) begin
            in_valid = 1'b0;
         end
         if (tx === f[s/DIV]) ok[s/DIV]++;
         if (done !== 1'b0) nd++;
         if (busy !== 1'b1 || in_ready !== 1'b0) nb++;
      end
      for (int b = 0; b < upto / DIV; b++)
         chk($sformatf("%s bit%0d", nm, b), ok[b], DIV);
      chk($sformatf("%s early done", nm), nd, 0);
      chk($sformatf("%s busy/ready", nm), nb, 0);
      if (upto == FLEN) begin
         @(negedge clk);
         chk($sformatf("%s done", nm), done, 1);
         chk($sformatf("%s idle tx", nm), tx, 1);
         chk($sformatf("%s idle ready", nm), in_ready, 1);
         chk($sformatf("%s idle busy", nm), busy, 0);
      end
   endtask

   task automatic idle_watch(input string nm, input int n);
      int nd;
      int nl;
      nd = 0;
      nl = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done !== 1'b0) nd++;
         if (tx !== 1'b1) nl++;
      end
      chk($sformatf("%s done count", nm), nd, 0);
      chk($sformatf("%s tx low count", nm), nl, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      soft_reset = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      vecs[0] = '{8'h55, 10'h2AA};
      vecs[1] = '{8'hA5, 10'h34A};
      vecs[2] = '{8'h81, 10'h302};
      vecs[3] = '{8'h3C, 10'h278};
      vecs[4] = '{8'h00, 10'h200};
      vecs[5] = '{8'hFF, 10'h3FE};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      chk("reset ready", in_ready, 1);
      chk("reset done", done, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].data, 1'b0);
         check_frame($sformatf("vec%0d", i),
                     full(vecs[i].data, vecs[i].frame), FLEN, -1);
      end

      // back-to-back with in_valid held high
      send(8'h00, 1'b1);
      in_data = 8'hFF;
      check_frame("b2b first", full(8'h00, 10'h200), FLEN, -1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check_frame("b2b second", full(8'hFF, 10'h3FE), FLEN, -1);

      // in_valid pulsed while busy must be dropped
      send(8'h55, 1'b0);
      check_frame("busy ign", full(8'h55, 10'h2AA), FLEN, 40);
      idle_watch("busy ign after", 200);

      // soft_reset beats a simultaneous handshake in IDLE
      @(posedge clk);
      #1;
      in_data    = 8'h42;
      in_valid   = 1'b1;
      soft_reset = 1'b1;
      #1 chk("sr prio ready", in_ready, 0);
      @(posedge clk);
      #1;
      soft_reset = 1'b0;
      in_valid   = 1'b0;
      chk("sr prio busy", busy, 0);
      chk("sr prio tx", tx, 1);
      idle_watch("sr prio after", 40);

      // soft_reset in data bit 3 of 0xA5
      send(8'hA5, 1'b0);
      check_frame("sr part", full(8'hA5, 10'h34A), 71, -1);
      soft_reset = 1'b1;
      @(posedge clk);
      #1 soft_reset = 1'b0;
      @(negedge clk);
      chk("sr tx", tx, 1);
      chk("sr busy", busy, 0);
      chk("sr done", done, 0);
      idle_watch("sr after", 200);
      send(8'h81, 1'b0);
      check_frame("sr next", full(8'h81, 10'h302), FLEN, -1);

      // async rst mid-frame
      send(8'hFF, 1'b0);
      check_frame("rst part", full(8'hFF, 10'h3FE), 50, -1);
      rst = 1'b1;
      #1;
      chk("arst tx", tx, 1);
      chk("arst busy", busy, 0);
      chk("arst ready", in_ready, 1);
      chk("arst done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      idle_watch("arst after", 200);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
